// File: rtl/irq_ctrl_pkg.sv
// Shared encodings and defaults for the interrupt controller.
// Holds FSM state encodings, default vector layout and id-width helper.
package irq_ctrl_pkg;

  typedef enum logic [0:0] {
    IrqSRun   = 1'b0,
    IrqSBlank = 1'b1
  } irq_state_e;

  localparam logic [15:0] IRQ_VEC_BASE_DEF   = 16'h0020;
  localparam int unsigned IRQ_VEC_STRIDE_DEF = 4;

  // Width of a channel id for n channels (never below 1 bit).
  function automatic int unsigned irq_id_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Lowest-index-first priority encoder: channel 0 wins.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned N = 8,
  localparam int unsigned W = irq_id_w(N)
) (
  input  logic [N-1:0] i_req,
  output logic [W-1:0] o_id,
  output logic         o_valid
);

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    o_id    = '0;
    o_valid = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_id    = W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Multi-source interrupt controller: edge/level latching, masking, priority
// selection and a bounded nesting stack with strict-priority preemption.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned      N_IRQ      = 8,
  parameter int unsigned      NEST_DEPTH = 4,
  parameter logic [15:0]      VEC_BASE   = IRQ_VEC_BASE_DEF,
  parameter int unsigned      VEC_STRIDE = IRQ_VEC_STRIDE_DEF,
  parameter logic [N_IRQ-1:0] MASK_RST   = {N_IRQ{1'b1}},
  localparam int unsigned     ID_W       = irq_id_w(N_IRQ),
  localparam int unsigned     NEST_W     = $clog2(NEST_DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_IRQ-1:0]  i_irq,
  input  logic [N_IRQ-1:0]  i_edge_mode,
  input  logic              i_mask_we,
  input  logic [N_IRQ-1:0]  i_mask_wdata,
  input  logic              i_int_en,
  input  logic              i_iret,
  output logic              o_irq_take,
  output logic [15:0]       o_vector,
  output logic [ID_W-1:0]   o_irq_id,
  output logic [N_IRQ-1:0]  o_pending,
  output logic [N_IRQ-1:0]  o_mask,
  output logic [NEST_W-1:0] o_nest_level,
  output logic              o_err
);

  logic [N_IRQ-1:0]  prev_q, prev_d;
  logic [N_IRQ-1:0]  pend_q, pend_d;
  logic [N_IRQ-1:0]  mask_q, mask_d;
  logic [N_IRQ-1:0]  insvc_q, insvc_d;
  logic [ID_W-1:0]   stack_q [NEST_DEPTH];
  logic [ID_W-1:0]   stack_d [NEST_DEPTH];
  logic [NEST_W-1:0] occ_q, occ_d;
  irq_state_e        state_q, state_d;
  logic              err_q, err_d;

  logic [N_IRQ-1:0]  eligible;
  logic [ID_W-1:0]   cand_id, top_id;
  logic              cand_valid, stack_empty, stack_full, allowed, take, pop;

  assign eligible = pend_q & mask_q & ~insvc_q;

  irq_prio_enc #(
    .N (N_IRQ)
  ) u_prio_enc (
    .i_req   (eligible),
    .o_id    (cand_id),
    .o_valid (cand_valid)
  );

  assign stack_empty = (occ_q == '0);
  assign stack_full  = (occ_q == NEST_W'(NEST_DEPTH));

  // Top of stack reads as 0 when empty so o_vector falls back to VEC_BASE.
  always_comb begin
    top_id = '0;
    for (int i = 0; i < int'(NEST_DEPTH); i++) begin
      if (occ_q == NEST_W'(i + 1)) top_id = stack_q[i];
    end
  end

  assign allowed = stack_empty | (cand_id < top_id);
  assign take    = i_int_en & cand_valid & allowed & (state_q == IrqSRun) & ~i_iret &
                   ~stack_full;
  assign pop     = i_iret & ~stack_empty;

  always_comb begin
    prev_d  = i_irq;
    pend_d  = pend_q;
    mask_d  = i_mask_we ? i_mask_wdata : mask_q;
    insvc_d = insvc_q;
    stack_d = stack_q;
    occ_d   = occ_q;
    state_d = state_q;
    err_d   = err_q | (i_iret & stack_empty);

    // A fresh edge in the take cycle re-arms the bit rather than losing it.
    for (int i = 0; i < int'(N_IRQ); i++) begin
      if (i_edge_mode[i]) begin
        pend_d[i] = (i_irq[i] & ~prev_q[i]) | (pend_q[i] & ~(take && cand_id == ID_W'(i)));
      end else begin
        pend_d[i] = i_irq[i];
      end
    end

    if (pop) begin
      occ_d = occ_q - NEST_W'(1);
      for (int i = 0; i < int'(N_IRQ); i++) begin
        if (top_id == ID_W'(i)) insvc_d[i] = 1'b0;
      end
    end

    if (take) begin
      occ_d = occ_q + NEST_W'(1);
      for (int i = 0; i < int'(NEST_DEPTH); i++) begin
        if (occ_q == NEST_W'(i)) stack_d[i] = cand_id;
      end
      for (int i = 0; i < int'(N_IRQ); i++) begin
        if (cand_id == ID_W'(i)) insvc_d[i] = 1'b1;
      end
    end

    unique case (state_q)
      IrqSRun:   if (take) state_d = IrqSBlank;
      IrqSBlank: state_d = IrqSRun;
      default:   state_d = IrqSRun;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_q  <= '0;
      pend_q  <= '0;
      mask_q  <= MASK_RST;
      insvc_q <= '0;
      for (int i = 0; i < int'(NEST_DEPTH); i++) stack_q[i] <= '0;
      occ_q   <= '0;
      state_q <= IrqSRun;
      err_q   <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      insvc_q <= insvc_d;
      stack_q <= stack_d;
      occ_q   <= occ_d;
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign o_irq_take   = take;
  assign o_vector     = VEC_BASE + 16'(take ? cand_id : top_id) * 16'(VEC_STRIDE);
  assign o_irq_id     = top_id;
  assign o_pending    = pend_q;
  assign o_mask       = mask_q;
  assign o_nest_level = occ_q;
  assign o_err        = err_q;

endmodule
